lsu_mem_scheduler: RTL and testbench

Registered, handshaked successor to the LSU issue selector. Each cycle it picks the oldest ready load from the LDQ or the oldest committed store from the STQ and holds it on a valid/ready memory request port until accepted. It tracks outstanding memory requests against a credit limit and guards committed stores against load starvation. It sits between the LDQ/STQ and the data-memory interface and reports which queue entry was issued.

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_priority_select.sv | 43 ++++
 rtl/lsu_mem_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_lsu_mem_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module : lsu_pkg
// Brief  : Shared types for the LSU memory-request scheduler.
// Rev    : 1.0  initial release
// ============================================================================
package lsu_pkg;

  // Request fields are stored at their widest supported size; users slice them down.
  localparam int unsigned LSU_MAX_XLEN  = 64;
  localparam int unsigned LSU_MAX_IDX_W = 16;

  typedef enum logic {
    MEM_LOAD  = 1'b0,
    MEM_STORE = 1'b1
  } mem_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } sched_state_e;

  typedef struct packed {
    mem_op_e                  op;
    logic [LSU_MAX_XLEN-1:0]  addr;
    logic [LSU_MAX_XLEN-1:0]  data;
    logic [LSU_MAX_IDX_W-1:0] index;
  } mem_req_t;

endpackage
`default_nettype wire

// File: rtl/lsu_priority_select.sv
`default_nettype none
// ============================================================================
// Module : lsu_priority_select
// Brief  : Oldest-ready pick over a head-rotated mask, returning an absolute index.
// Rev    : 1.0  initial release
// ============================================================================
module lsu_priority_select #(
  parameter int unsigned SIZE  = 32,
  parameter int unsigned IDX_W = $clog2(SIZE)
) (
  input  logic [SIZE-1:0]  ready_rot,
  input  logic [IDX_W-1:0] head,
  input  logic             excl_valid,
  input  logic [IDX_W-1:0] excl_idx,
  output logic             sel_valid,
  output logic [IDX_W-1:0] sel_idx
);

  logic [SIZE-1:0]  masked;
  logic [IDX_W-1:0] excl_rot;
  logic [IDX_W-1:0] rot_idx;

  assign excl_rot = excl_idx - head;

  always_comb begin
    masked = ready_rot;
    if (excl_valid) begin
      masked[excl_rot] = 1'b0;
    end
    rot_idx = '0;
    // Descending scan so the lowest set bit (the oldest entry) wins.
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (masked[i]) begin
        rot_idx = IDX_W'(i);
      end
    end
  end

  assign sel_valid = |masked;
  assign sel_idx   = rot_idx + head;

endmodule
`default_nettype wire

// File: rtl/lsu_mem_scheduler.sv
`default_nettype none
// ============================================================================
// Module : lsu_mem_scheduler
// Brief  : Picks the oldest ready load or committed store and holds it on a
//          valid/ready memory port, with credit tracking and starvation guard
//          (starvation guard enabled by defining LSU_STARVE_GUARD_EN).
// Rev    : 1.0  initial release
// ============================================================================
module lsu_mem_scheduler
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned LDQ_SIZE        = 32,
  parameter int unsigned STQ_SIZE        = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned STARVE_LIMIT    = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic [LDQ_SIZE-1:0][XLEN-1:0]    ldq_address,
  input  logic [LDQ_SIZE-1:0]              ldq_rotated_valid,
  input  logic [LDQ_SIZE-1:0]              ldq_rotated_address_valid,
  input  logic [LDQ_SIZE-1:0]              ldq_rotated_sleeping,
  input  logic [LDQ_SIZE-1:0]              ldq_rotated_executed,
  input  logic [STQ_SIZE-1:0][XLEN-1:0]    stq_address,
  input  logic [STQ_SIZE-1:0][XLEN-1:0]    stq_data,
  input  logic [STQ_SIZE-1:0]              stq_rotated_valid,
  input  logic [STQ_SIZE-1:0]              stq_rotated_committed,
  input  logic [$clog2(LDQ_SIZE)-1:0]      ldq_head,
  input  logic [$clog2(STQ_SIZE)-1:0]      stq_head,
  input  logic                             stq_full,
  output logic                             mem_req_valid,
  input  logic                             mem_req_ready,
  output logic                             mem_req_type,
  output logic [XLEN-1:0]                  mem_req_addr,
  output logic [XLEN-1:0]                  mem_req_data,
  input  logic                             mem_resp_valid,
  output logic                             load_fired,
  output logic [$clog2(LDQ_SIZE)-1:0]      load_fired_ldq_index,
  output logic                             store_fired,
  output logic [$clog2(STQ_SIZE)-1:0]      store_fired_index
);

  localparam int unsigned LDQ_IDX_W = $clog2(LDQ_SIZE);
  localparam int unsigned STQ_IDX_W = $clog2(STQ_SIZE);
  localparam int unsigned CNT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] c_max_out = CNT_W'(MAX_OUTSTANDING);

  sched_state_e         state_q, state_d;
  mem_req_t             req_q, req_d, w_new_req;
  logic [CNT_W-1:0]     outstanding_q, outstanding_d;
  logic                 w_accept, w_resp_eff, w_cand, w_pick_store, w_force_store;
  logic                 w_ld_sel, w_st_sel;
  logic [LDQ_IDX_W-1:0] w_ld_idx;
  logic [STQ_IDX_W-1:0] w_st_idx;
  logic [STQ_SIZE-1:0]  w_st_ready;
  logic                 w_unused_req_bits;

  assign w_st_ready = stq_rotated_valid & stq_rotated_committed;

  lsu_priority_select #(.SIZE(LDQ_SIZE)) u_ldq_sel (
    .ready_rot  (ldq_rotated_valid & ldq_rotated_address_valid
                 & ~ldq_rotated_sleeping & ~ldq_rotated_executed),
    .head       (ldq_head),
    .excl_valid (state_q == HOLD && req_q.op == MEM_LOAD),
    .excl_idx   (req_q.index[LDQ_IDX_W-1:0]),
    .sel_valid  (w_ld_sel),
    .sel_idx    (w_ld_idx)
  );

  lsu_priority_select #(.SIZE(STQ_SIZE)) u_stq_sel (
    .ready_rot  (w_st_ready),
    .head       (stq_head),
    .excl_valid (state_q == HOLD && req_q.op == MEM_STORE),
    .excl_idx   (req_q.index[STQ_IDX_W-1:0]),
    .sel_valid  (w_st_sel),
    .sel_idx    (w_st_idx)
  );

  assign w_accept   = (state_q == HOLD) && mem_req_ready;
  assign w_resp_eff = mem_resp_valid && (outstanding_q != '0);

`ifdef LSU_STARVE_GUARD_EN
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] c_starve_limit = STARVE_W'(STARVE_LIMIT);
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if ((w_accept && req_q.op == MEM_STORE) || !(|w_st_ready)) begin
      starve_cnt_d = '0;
    end else if (w_accept && starve_cnt_q != c_starve_limit) begin
      starve_cnt_d = starve_cnt_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) starve_cnt_q <= '0;
    else       starve_cnt_q <= starve_cnt_d;
  end

  // Uses the post-acceptance count so the pick made alongside the
  // limit-reaching load already switches to the store.
  assign w_force_store = (starve_cnt_d >= c_starve_limit);
`else
  logic w_unused_starve_limit;
  assign w_unused_starve_limit = (STARVE_LIMIT != 0);
  assign w_force_store         = 1'b0;
`endif

  assign w_cand       = w_ld_sel || w_st_sel;
  assign w_pick_store = w_st_sel && (stq_full || w_force_store || !w_ld_sel);

  always_comb begin
    w_new_req = '0;
    if (w_pick_store) begin
      w_new_req.op    = MEM_STORE;
      w_new_req.addr  = LSU_MAX_XLEN'(stq_address[w_st_idx]);
      w_new_req.data  = LSU_MAX_XLEN'(stq_data[w_st_idx]);
      w_new_req.index = LSU_MAX_IDX_W'(w_st_idx);
    end else begin
      w_new_req.op    = MEM_LOAD;
      w_new_req.addr  = LSU_MAX_XLEN'(ldq_address[w_ld_idx]);
      w_new_req.index = LSU_MAX_IDX_W'(w_ld_idx);
    end
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (w_accept && !w_resp_eff) begin
      if (outstanding_q != c_max_out) outstanding_d = outstanding_q + CNT_W'(1);
    end else if (!w_accept && w_resp_eff) begin
      outstanding_d = outstanding_q - CNT_W'(1);
    end
  end

  always_comb begin
    logic load_new;
    load_new = 1'b0;
    state_d  = state_q;
    req_d    = req_q;
    if (state_q == IDLE) begin
      load_new = w_cand && !flush && (outstanding_q < c_max_out);
    end else if (flush) begin
      // Committed stores survive a flush; a held load is withdrawn.
      if (w_accept || req_q.op == MEM_LOAD) state_d = IDLE;
    end else if (w_accept) begin
      if (w_cand && (outstanding_d < c_max_out)) load_new = 1'b1;
      else                                       state_d  = IDLE;
    end
    if (load_new) begin
      state_d = HOLD;
      req_d   = w_new_req;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      req_q         <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign mem_req_valid        = (state_q == HOLD);
  assign mem_req_type         = req_q.op;
  assign mem_req_addr         = req_q.addr[XLEN-1:0];
  assign mem_req_data         = req_q.data[XLEN-1:0];
  assign load_fired           = w_accept && (req_q.op == MEM_LOAD);
  assign store_fired          = w_accept && (req_q.op == MEM_STORE);
  assign load_fired_ldq_index = req_q.index[LDQ_IDX_W-1:0];
  assign store_fired_index    = req_q.index[STQ_IDX_W-1:0];
  assign w_unused_req_bits    = ^req_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_lsu_mem_scheduler
// Brief  : Directed and randomized bench for lsu_mem_scheduler against a
//          behavioural queue-scan reference model (honours LSU_STARVE_GUARD_EN).
// Rev    : 1.0  initial release
// ============================================================================
module tb_lsu_mem_scheduler;

  localparam int XLEN = 32;
  localparam int LQ   = 32;
  localparam int SQ   = 32;
  localparam int MAXO = 4;
  localparam int LIM  = 3;

  logic                    clk = 1'b0;
  logic                    reset, flush, stq_full, mem_req_ready, mem_resp_valid;
  logic [LQ-1:0][XLEN-1:0] ldq_address;
  logic [LQ-1:0]           ldq_v, ldq_av, ldq_sl, ldq_ex;
  logic [SQ-1:0][XLEN-1:0] stq_address, stq_data;
  logic [SQ-1:0]           stq_v, stq_c;
  logic [4:0]              ldq_head, stq_head;
  logic                    mem_req_valid, mem_req_type, load_fired, store_fired;
  logic [XLEN-1:0]         mem_req_addr, mem_req_data;
  logic [4:0]              load_fired_ldq_index, store_fired_index;

  lsu_mem_scheduler #(
    .XLEN(XLEN), .LDQ_SIZE(LQ), .STQ_SIZE(SQ),
    .MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .ldq_address(ldq_address),
    .ldq_rotated_valid(ldq_v), .ldq_rotated_address_valid(ldq_av),
    .ldq_rotated_sleeping(ldq_sl), .ldq_rotated_executed(ldq_ex),
    .stq_address(stq_address), .stq_data(stq_data),
    .stq_rotated_valid(stq_v), .stq_rotated_committed(stq_c),
    .ldq_head(ldq_head), .stq_head(stq_head), .stq_full(stq_full),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_type(mem_req_type), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_resp_valid(mem_resp_valid),
    .load_fired(load_fired), .load_fired_ldq_index(load_fired_ldq_index),
    .store_fired(store_fired), .store_fired_index(store_fired_index)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int obs_ld = 0;
  int obs_st = 0;

  // Reference model: pending request plus credit and starvation counts.
  bit              m_valid, m_store;
  logic [XLEN-1:0] m_addr, m_data;
  int              m_idx, m_out, m_starve;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_store = 0; m_addr = '0; m_data = '0;
    m_idx = 0; m_out = 0; m_starve = 0;
  endtask

  task automatic clear_inputs();
    flush = 0; stq_full = 0; mem_req_ready = 0; mem_resp_valid = 0;
    ldq_v = '0; ldq_av = '0; ldq_sl = '0; ldq_ex = '0;
    stq_v = '0; stq_c = '0; ldq_head = '0; stq_head = '0;
  endtask

  task automatic randomize_addresses();
    for (int i = 0; i < LQ; i++) ldq_address[i] = $urandom;
    for (int i = 0; i < SQ; i++) begin
      stq_address[i] = $urandom;
      stq_data[i]    = $urandom;
    end
  endtask

  task automatic model_advance(input bit fire);
    int  ld_pick, st_pick, n_out, n_starve, a;
    bit  any_st, pick_st, take;
    ld_pick = -1; st_pick = -1; any_st = 0; take = 0;
    for (int r = 0; r < LQ; r++) begin
      a = (int'(ldq_head) + r) % LQ;
      if (ldq_v[r] && ldq_av[r] && !ldq_sl[r] && !ldq_ex[r] && ld_pick < 0
          && !(m_valid && !m_store && m_idx == a)) ld_pick = a;
    end
    for (int r = 0; r < SQ; r++) begin
      a = (int'(stq_head) + r) % SQ;
      if (stq_v[r] && stq_c[r]) begin
        any_st = 1;
        if (st_pick < 0 && !(m_valid && m_store && m_idx == a)) st_pick = a;
      end
    end
    n_out = m_out;
    if (fire && !(mem_resp_valid && m_out > 0)) n_out = (m_out + 1 > MAXO) ? MAXO : m_out + 1;
    else if (!fire && mem_resp_valid && m_out > 0) n_out = m_out - 1;
    n_starve = 0;
    pick_st  = (st_pick >= 0) && (stq_full || ld_pick < 0);
`ifdef LSU_STARVE_GUARD_EN
    n_starve = m_starve;
    if ((fire && m_store) || !any_st) n_starve = 0;
    else if (fire) n_starve = (m_starve + 1 > LIM) ? LIM : m_starve + 1;
    if (st_pick >= 0 && n_starve >= LIM) pick_st = 1;
`endif
    if (flush) begin
      if (fire || (m_valid && !m_store)) m_valid = 0;
    end else if (!m_valid) begin
      take = (ld_pick >= 0 || st_pick >= 0) && m_out < MAXO;
    end else if (fire) begin
      take = (ld_pick >= 0 || st_pick >= 0) && n_out < MAXO;
      if (!take) m_valid = 0;
    end
    if (take) begin
      m_valid = 1;
      m_store = pick_st;
      m_idx   = pick_st ? st_pick : ld_pick;
      m_addr  = pick_st ? stq_address[st_pick] : ldq_address[ld_pick];
      m_data  = pick_st ? stq_data[st_pick] : '0;
    end
    m_out    = n_out;
    m_starve = n_starve;
  endtask

  task automatic step();
    bit fire;
    #1;
    fire = m_valid && mem_req_ready;
    if (load_fired === 1'b1) obs_ld++;
    if (store_fired === 1'b1) obs_st++;
    check_eq("req_valid", mem_req_valid, m_valid);
    if (m_valid) begin
      check_eq("req_type", mem_req_type, m_store);
      check_eq("req_addr", mem_req_addr, m_addr);
      check_eq("req_data", mem_req_data, m_data);
    end
    check_eq("load_fired", load_fired, fire && !m_store);
    check_eq("store_fired", store_fired, fire && m_store);
    if (fire && !m_store) check_eq("load_idx", load_fired_ldq_index, m_idx);
    if (fire && m_store) check_eq("store_idx", store_fired_index, m_idx);
    model_advance(fire);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge clk);
    reset = 1;
    model_reset();
    @(negedge clk);
    reset = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, mem_req_valid, 0);
    check_eq({tag, "_type"}, mem_req_type, 0);
    check_eq({tag, "_addr"}, mem_req_addr, 0);
    check_eq({tag, "_data"}, mem_req_data, 0);
    check_eq({tag, "_lfire"}, load_fired, 0);
    check_eq({tag, "_sfire"}, store_fired, 0);
    check_eq({tag, "_lidx"}, load_fired_ldq_index, 0);
    check_eq({tag, "_sidx"}, store_fired_index, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, loads_before, st0;
    reset = 1;
    clear_inputs();
    randomize_addresses();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("rst");
    reset = 0;
    @(negedge clk);

    // Single ready load at rotated bit 3 with head 30 wraps to index 1.
    ldq_head = 5'd30; ldq_v = 32'h8; ldq_av = 32'h8;
    step();
    mem_req_ready = 1;
    #1;
    check_eq("wrap_fire", load_fired, 1);
    check_eq("wrap_idx", load_fired_ldq_index, 1);
    step();

    // Backpressure while an older load appears: held request stays stable.
    do_reset();
    ldq_v = 32'h20; ldq_av = 32'h20;
    step();
    ldq_v = 32'h24; ldq_av = 32'h24;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("hold_addr", mem_req_addr, ldq_address[5]);
      step();
    end
    mem_req_ready = 1;
    #1;
    check_eq("hold_first_idx", load_fired_ldq_index, 5);
    step();
    step();

    // Credit limit with no responses, then one response frees a slot.
    do_reset();
    ldq_v = 32'hFF; ldq_av = 32'hFF; mem_req_ready = 1;
    base = obs_ld;
    repeat (10) step();
    check_eq("credit_fires", obs_ld - base, MAXO);
    #1;
    check_eq("credit_stall", mem_req_valid, 0);
    mem_resp_valid = 1;
    step();
    mem_resp_valid = 0;
    step();
    #1;
    check_eq("credit_reissue", mem_req_valid, 1);
    step();

    // Loads and a store continuously ready: starvation guard behaviour.
    do_reset();
    ldq_v = 32'hFF; ldq_av = 32'hFF; stq_v = 32'h1; stq_c = 32'h1; mem_req_ready = 1;
    base = obs_ld; st0 = obs_st; loads_before = -1;
    for (int i = 0; i < 12; i++) begin
      mem_resp_valid = (m_out > 0);
      step();
      if (obs_st > st0 && loads_before < 0) loads_before = obs_ld - base;
    end
`ifdef LSU_STARVE_GUARD_EN
    check_eq("starve_loads", loads_before, LIM);
`else
    check_eq("starve_no_store", obs_st - st0, 0);
`endif

    // Flush withdraws a held load but keeps a held store.
    do_reset();
    ldq_v = 32'h10; ldq_av = 32'h10;
    step();
    ldq_v = '0; ldq_av = '0; flush = 1;
    step();
    flush = 0;
    #1;
    check_eq("flush_load_drop", mem_req_valid, 0);
    step();
    stq_v = 32'h4; stq_c = 32'h4;
    step();
    stq_v = '0; stq_c = '0; flush = 1;
    step();
    flush = 0; mem_req_ready = 1;
    #1;
    check_eq("flush_store_fire", store_fired, 1);
    check_eq("flush_store_idx", store_fired_index, 2);
    step();

    // Asynchronous reset while holding with three requests outstanding.
    do_reset();
    ldq_v = 32'hFF; ldq_av = 32'hFF; mem_req_ready = 1;
    for (int i = 0; i < 10 && !(m_out == 3 && m_valid); i++) step();
    mem_req_ready = 0;
    #1;
    check_eq("pre_reset_valid", mem_req_valid, 1);
    reset = 1;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    reset = 0;
    mem_req_ready = 1;
    base = obs_ld;
    repeat (10) step();
    check_eq("post_rst_credit", obs_ld - base, MAXO);

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c % 50 == 0) randomize_addresses();
      ldq_head = 5'($urandom);
      stq_head = 5'($urandom);
      ldq_v  = $urandom;
      ldq_av = $urandom | $urandom;
      ldq_sl = $urandom & $urandom & $urandom;
      ldq_ex = $urandom & $urandom;
      if ($urandom_range(3) == 0) ldq_v = '0;
      stq_v = ($urandom_range(1) == 0) ? '0 : ($urandom & $urandom);
      stq_c = $urandom;
      stq_full = ($urandom_range(7) == 0);
      flush = ($urandom_range(15) == 0);
      mem_req_ready = flush ? 1'b0 : ($urandom_range(2) != 0);
      mem_resp_valid = (m_out > 0) && ($urandom_range(1) == 1);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
